hbridge_driver: RTL and testbench

//  Consumes the 4-bit DIR command from DirectionControl and drives two H-bridge channels (right, left).
//  Per channel: dead-time insertion on every drive/brake change (no shoot-through), plus PWM speed control on EN.

---
 rtl/hbridge_if.sv | 11 +
 rtl/hbridge_driver.sv | 117 +++++++++++
 tb/tb_hbridge_driver.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/hbridge_if.sv
// hbridge_if: command inputs and bridge pin outputs of the dual H-bridge driver
// DIR   [1:0] right cmd, [3:2] left cmd (00 coast, 01 fwd, 10 rev, 11 brake)
// duty  PWM duty, EN high for duty/256 of each period
// R_*/L_* bridge IN1/IN2/EN pins; busy high while either channel is in dead time
interface hbridge_if;
  logic [3:0] DIR;
  logic [7:0] duty;
  logic R_IN1, R_IN2, R_EN, L_IN1, L_IN2, L_EN, busy;
  modport master (output DIR, duty, input R_IN1, R_IN2, R_EN, L_IN1, L_IN2, L_EN, busy);
  modport slave (input DIR, duty, output R_IN1, R_IN2, R_EN, L_IN1, L_IN2, L_EN, busy);
endinterface

// File: rtl/hbridge_driver.sv
// hbridge_driver: two H-bridge channels with dead-time insertion and shared PWM on EN
// clk  system clock, rising edge
// rst  asynchronous active-high reset
// bus  hbridge_if.slave: DIR/duty in, bridge pins and busy out (all registered)
module hbridge_driver #(
  parameter int DEADTIME = 25,
  parameter int PRESCALE = 4
) (
  input  logic      clk,
  input  logic      rst,
  hbridge_if.slave  bus
);
  localparam int CW = DEADTIME > 1 ? $clog2(DEADTIME) : 1;
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(DEADTIME - 1);
  localparam logic [PW-1:0] PTOP = PW'(PRESCALE - 1);
  typedef enum logic [1:0] {IDLE, DEAD, DRIVE, BRAKE} state_t;
  logic [3:0] dir_q, dir_d;
  logic [7:0] duty_q, duty_d, pwm_cnt_q, pwm_cnt_d;
  logic [PW-1:0] presc_q, presc_d;
  logic wrap, pwm;
  state_t state_q [2];
  state_t state_d [2];
  logic [1:0] cur_q [2];
  logic [1:0] cur_d [2];
  logic [1:0] cmd [2];
  logic [CW-1:0] cnt_q [2];
  logic [CW-1:0] cnt_d [2];
  logic [1:0] in1_q, in1_d, in2_q, in2_d, en_q, en_d;
  logic busy_q, busy_d;
  // duty only reloads at the 255->0 wrap so a period never mixes two widths
  always_comb begin
    dir_d = bus.DIR;
    wrap = presc_q == PTOP;
    presc_d = wrap ? '0 : presc_q + 1'b1;
    pwm_cnt_d = pwm_cnt_q + 8'(wrap);
    duty_d = (wrap && pwm_cnt_q == 8'hff) ? bus.duty : duty_q;
    pwm = pwm_cnt_q < duty_q;
  end
  // index 0 = right (DIR[1:0]), index 1 = left (DIR[3:2]); outputs follow the next state
  always_comb begin
    in1_d = '0;
    in2_d = '0;
    en_d = '0;
    for (int c = 0; c < 2; c++) begin
      cmd[c] = dir_q[2*c +: 2];
      state_d[c] = state_q[c];
      cur_d[c] = cur_q[c];
      cnt_d[c] = cnt_q[c];
      case (state_q[c])
        IDLE:
          if (cmd[c] != 2'b00) begin
            state_d[c] = DEAD;
            cnt_d[c] = RELOAD;
            cur_d[c] = cmd[c];
          end
        DEAD:
          if (cmd[c] == 2'b00) state_d[c] = IDLE;
          else if (cmd[c] != cur_q[c]) begin
            cur_d[c] = cmd[c];
            cnt_d[c] = RELOAD;
          end
          else if (cnt_q[c] == '0) state_d[c] = (cur_q[c] == 2'b11) ? BRAKE : DRIVE;
          else cnt_d[c] = cnt_q[c] - 1'b1;
        default:
          if (cmd[c] == 2'b00) state_d[c] = IDLE;
          else if (cmd[c] != cur_q[c]) begin
            state_d[c] = DEAD;
            cnt_d[c] = RELOAD;
            cur_d[c] = cmd[c];
          end
      endcase
      in1_d[c] = state_d[c] == BRAKE || (state_d[c] == DRIVE && cur_d[c] == 2'b01);
      in2_d[c] = state_d[c] == BRAKE || (state_d[c] == DRIVE && cur_d[c] == 2'b10);
      en_d[c] = state_d[c] == BRAKE || (state_d[c] == DRIVE && pwm);
    end
    busy_d = state_d[0] == DEAD || state_d[1] == DEAD;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dir_q <= '0;
      duty_q <= '0;
      pwm_cnt_q <= '0;
      presc_q <= '0;
      in1_q <= '0;
      in2_q <= '0;
      en_q <= '0;
      busy_q <= 1'b0;
      for (int c = 0; c < 2; c++) begin
        state_q[c] <= IDLE;
        cur_q[c] <= '0;
        cnt_q[c] <= '0;
      end
    end else begin
      dir_q <= dir_d;
      duty_q <= duty_d;
      pwm_cnt_q <= pwm_cnt_d;
      presc_q <= presc_d;
      in1_q <= in1_d;
      in2_q <= in2_d;
      en_q <= en_d;
      busy_q <= busy_d;
      for (int c = 0; c < 2; c++) begin
        state_q[c] <= state_d[c];
        cur_q[c] <= cur_d[c];
        cnt_q[c] <= cnt_d[c];
      end
    end
  end
  assign bus.R_IN1 = in1_q[0];
  assign bus.R_IN2 = in2_q[0];
  assign bus.R_EN = en_q[0];
  assign bus.L_IN1 = in1_q[1];
  assign bus.L_IN2 = in2_q[1];
  assign bus.L_EN = en_q[1];
  assign bus.busy = busy_q;
endmodule

// File: tb/tb_hbridge_driver.sv
// tb_hbridge_driver: directed checks of dead time, PWM, brake, restart and async reset
module tb_hbridge_driver;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;
  hbridge_if bus ();
  hbridge_driver #(.DEADTIME(4), .PRESCALE(1)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #20 clk = ~clk;
  logic [6:0] obs;
  assign obs = {bus.R_IN1, bus.R_IN2, bus.R_EN, bus.L_IN1, bus.L_IN2, bus.L_EN, bus.busy};
  logic [1:0] prev_r = 2'b00, prev_l = 2'b00;
  always @(negedge clk) if (!rst) begin
    checks++;
    if ((bus.R_IN1 & bus.R_IN2 & !bus.R_EN) || (bus.L_IN1 & bus.L_IN2 & !bus.L_EN)) begin
      errors++;
      $display("FAIL brake_en obs=%b required EN=1 when IN1&IN2", obs);
    end
    checks++;
    if (((prev_r == 2'b01 || prev_r == 2'b10) && (^{bus.R_IN1, bus.R_IN2}) && prev_r != {bus.R_IN1, bus.R_IN2}) ||
        ((prev_l == 2'b01 || prev_l == 2'b10) && (^{bus.L_IN1, bus.L_IN2}) && prev_l != {bus.L_IN1, bus.L_IN2})) begin
      errors++;
      $display("FAIL shoot_through prev_r=%b prev_l=%b obs=%b required 00 between", prev_r, prev_l, obs);
    end
    prev_r <= {bus.R_IN1, bus.R_IN2};
    prev_l <= {bus.L_IN1, bus.L_IN2};
  end
  initial begin
    #1ms;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  task automatic test_reset;
    rst = 1'b1;
    bus.DIR = 4'b0000;
    bus.duty = 8'd128;
    repeat (2) @(negedge clk);
    checks++;
    if (obs !== 7'b0) begin errors++; $display("FAIL reset_hold obs=%b required 0000000", obs); end
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== 7'b0) begin errors++; $display("FAIL idle_zero cyc %0d obs=%b required 0000000", i, obs); end
    end
  endtask
  task automatic test_forward;
    int hi, lbad;
    bus.DIR = 4'b0001;
    @(negedge clk);
    checks++;
    if (obs !== 7'b0) begin errors++; $display("FAIL fwd_sample obs=%b required 0000000", obs); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== 7'b0000001) begin errors++; $display("FAIL fwd_dead %0d obs=%b required 0000001", i, obs); end
    end
    @(negedge clk);
    checks++;
    if ({bus.R_IN1, bus.R_IN2, bus.L_IN1, bus.L_IN2, bus.L_EN, bus.busy} !== 6'b100000) begin
      errors++; $display("FAIL fwd_drive obs=%b required 10x0000", obs);
    end
    repeat (300) @(negedge clk);
    hi = 0;
    lbad = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      hi += int'(bus.R_EN);
      if ({bus.L_IN1, bus.L_IN2, bus.L_EN} !== 3'b000) lbad++;
    end
    checks++;
    if (hi != 128) begin errors++; $display("FAIL pwm_128 high=%0d required 128", hi); end
    checks++;
    if (lbad != 0) begin errors++; $display("FAIL left_quiet nonzero=%0d required 0", lbad); end
  endtask
  task automatic test_reverse;
    bus.DIR = 4'b0010;
    @(negedge clk);
    checks++;
    if ({bus.R_IN1, bus.R_IN2} !== 2'b10) begin errors++; $display("FAIL rev_hold in=%b%b required 10", bus.R_IN1, bus.R_IN2); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== 7'b0000001) begin errors++; $display("FAIL rev_dead %0d obs=%b required 0000001", i, obs); end
    end
    @(negedge clk);
    checks++;
    if ({bus.R_IN1, bus.R_IN2, bus.busy} !== 3'b010) begin errors++; $display("FAIL rev_drive obs=%b required 01x0000", obs); end
  endtask
  task automatic test_brake;
    bus.duty = 8'd0;
    bus.DIR = 4'b1100;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== 7'b0000001) begin errors++; $display("FAIL brk_dead %0d obs=%b required 0000001", i, obs); end
    end
    @(negedge clk);
    checks++;
    if (obs !== 7'b0001110) begin errors++; $display("FAIL brake_on obs=%b required 0001110", obs); end
    bus.DIR = 4'b0000;
    @(negedge clk);
    checks++;
    if (obs !== 7'b0001110) begin errors++; $display("FAIL brake_hold obs=%b required 0001110", obs); end
    @(negedge clk);
    checks++;
    if (obs !== 7'b0) begin errors++; $display("FAIL brake_coast obs=%b required 0000000", obs); end
  endtask
  task automatic test_restart;
    int hi;
    logic prev, found;
    bus.duty = 8'd64;
    bus.DIR = 4'b0001;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== 7'b0000001) begin errors++; $display("FAIL rst_dead_a %0d obs=%b required 0000001", i, obs); end
    end
    bus.DIR = 4'b0010;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== 7'b0000001) begin errors++; $display("FAIL rst_dead_b %0d obs=%b required 0000001", i, obs); end
    end
    @(negedge clk);
    checks++;
    if ({bus.R_IN1, bus.R_IN2, bus.busy} !== 3'b010) begin errors++; $display("FAIL restart_rev obs=%b required 01x0000", obs); end
    repeat (600) @(negedge clk);
    found = 1'b0;
    prev = bus.R_EN;
    for (int i = 0; i < 600 && !found; i++) begin
      @(negedge clk);
      if (!prev && bus.R_EN) found = 1'b1;
      prev = bus.R_EN;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL pwm_rise found=0 required 1"); end
    else begin
      hi = 1;
      bus.duty = 8'd200;
      for (int i = 0; i < 255; i++) begin
        @(negedge clk);
        hi += int'(bus.R_EN);
      end
      checks++;
      if (hi != 64) begin errors++; $display("FAIL duty_old high=%0d required 64", hi); end
      hi = 0;
      for (int i = 0; i < 256; i++) begin
        @(negedge clk);
        hi += int'(bus.R_EN);
      end
      checks++;
      if (hi != 200) begin errors++; $display("FAIL duty_new high=%0d required 200", hi); end
    end
  endtask
  task automatic test_async_reset;
    #5 rst = 1'b1;
    #5;
    checks++;
    if (obs !== 7'b0) begin errors++; $display("FAIL async_clear obs=%b required 0000000", obs); end
    #5 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (obs !== 7'b0) begin errors++; $display("FAIL post_rst obs=%b required 0000000", obs); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== 7'b0000001) begin errors++; $display("FAIL post_rst_dead %0d obs=%b required 0000001", i, obs); end
    end
    @(negedge clk);
    checks++;
    if ({bus.R_IN1, bus.R_IN2, bus.busy} !== 3'b010) begin errors++; $display("FAIL post_rst_drive obs=%b required 01x0000", obs); end
  endtask
  initial begin
    test_reset();
    test_forward();
    test_reverse();
    test_brake();
    test_restart();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
